temp_log_buffer: RTL and testbench
==================================

# temp_log_buffer

Receive-side logging stage that sits directly downstream of the UART receiver. It accepts each received temperature byte together with the current real-time-clock fields, discards bytes flagged with a parity error, and stores good samples as timestamped records in a circular buffer for readout. It also tracks the running minimum and maximum temperature and drives an over-temperature flag with hysteresis.

## Interface
Parameters:
- DEPTH, 16: number of records held; must be a power of two, minimum 2.
- HI_THRESH, 8'd200: a sample at or above this value sets the alarm.
- LO_THRESH, 8'd180: a sample below this value clears the alarm; must be less than HI_THRESH.

Ports:
- clk  in  1  single system clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received temperature byte.
- rx_valid  in  1  one-cycle strobe; rx_data and rx_parity_error are valid while it is high.
- rx_parity_error  in  1  the byte presented with this strobe failed the parity check.
- seconds  in  6  RTC seconds.
- minutes  in  6  RTC minutes.
- hours  in  5  RTC hours.
- days  in  5  RTC days.
- months  in  4  RTC months.
- rd_en  in  1  pop the oldest record.
- rd_data  out  34  popped record, packed as {months, days, hours, minutes, seconds, temp}.
- rd_valid  out  1  one-cycle strobe; rd_data is valid while it is high.
- count  out  log2(DEPTH)+1  number of records currently stored.
- empty  out  1  high when count == 0.
- full  out  1  high when count == DEPTH.
- drop_count  out  8  number of records overwritten; saturates at 255.
- err_count  out  8  number of parity-error bytes discarded; saturates at 255.
- temp_min  out  8  lowest accepted sample.
- temp_max  out  8  highest accepted sample.
- alarm  out  1  over-temperature flag.

## Operation
- Accept condition: rx_valid=1 and rx_parity_error=0.
  - The record is built from rx_data and the RTC inputs sampled in the same cycle.
  - The record is written at the write pointer, and the write pointer increments modulo DEPTH.
- Parity-error byte (rx_valid=1 and rx_parity_error=1):
  - Not stored.
  - err_count increments, saturating at 255.
  - min, max and alarm are unchanged.
- Pop condition: rd_en=1 and count>0.
  - rd_data is loaded from the read pointer and rd_valid pulses.
  - The read pointer increments modulo DEPTH.
  - rd_en with count==0 is ignored: rd_valid stays 0 and rd_data holds its last value.
- Accept while full, no pop in the same cycle:
  - The oldest record is overwritten.
  - Both pointers advance and count stays at DEPTH.
  - drop_count increments, saturating at 255.
- Accept and pop in the same cycle:
  - The pop takes the oldest existing record.
  - The new record is written and count is unchanged.
  - drop_count does not increment, even when full.
- Accept and pop in the same cycle while empty:
  - The pop is ignored (rd_valid=0).
  - The push happens and count becomes 1.
- Statistics, updated on accept only:
  - temp_min = min(temp_min, rx_data).
  - temp_max = max(temp_max, rx_data).
- Alarm state machine, two states NORMAL/ALARM, evaluated on accept only:
  - NORMAL -> ALARM when rx_data >= HI_THRESH.
  - ALARM -> NORMAL when rx_data < LO_THRESH.
  - Otherwise the state is held.
  - alarm=1 exactly when the state is ALARM.
- Comparisons are unsigned 8-bit.
- count never exceeds DEPTH. The pointers are log2(DEPTH) bits wide and wrap naturally.

## Timing
- Reset (synchronous, takes effect on the clock edge with reset=1) values:
  - Pointers and count: 0.
  - empty=1, full=0.
  - rd_valid=0, rd_data=0.
  - drop_count=0, err_count=0.
  - temp_min=8'hFF, temp_max=8'h00.
  - Alarm state NORMAL (alarm=0).
- Reset overrides every same-cycle accept or pop. A reset during any operation discards all stored records.
- Accept at edge N:
  - count, empty, full, min, max and alarm show the new values after edge N (one-cycle latency).
  - The record can be popped by rd_en sampled at edge N+1.
- Pop at edge N: rd_data and rd_valid are registered after edge N; rd_valid is high for exactly one cycle per pop.
- Back-to-back rd_en: one record per cycle until empty.
- Back-to-back rx_valid: one record per cycle.
- The RTC fields are sampled only in the accept cycle. Any RTC rollover in that cycle is captured as presented.

## Test plan
- Reset, then accept 0x19, 0x1E, 0x14 at RTC 00:00:05, then 3 pops:
  - rd_data temperatures 0x19, 0x1E, 0x14 in that order, each with seconds=5.
  - count goes 3 -> 0 and empty=1.
  - temp_min=0x14, temp_max=0x1E.
- Accept 18 bytes 0x00..0x11 with DEPTH=16 and no pops:
  - full=1, count=16, drop_count=2.
  - Pops return 0x02..0x11.
  - The 17th pop gives rd_valid=0.
- Byte 0x50 with rx_parity_error=1:
  - count unchanged, err_count=1.
  - min/max unchanged; pop while empty gives rd_valid=0.
- Alarm sequence 190, 200, 185, 179, 199:
  - alarm after each accept: 0, 1, 1, 0, 0.
- Full buffer, then accept 0xAA and pop in the same cycle:
  - The pop returns the oldest record, count stays 16, drop_count unchanged.
  - 0xAA is the last record popped.
- 300 parity errors, then reset asserted mid-stream:
  - err_count saturates at 255.
  - After reset, all outputs equal their reset values.

Source files
------------

// File: rtl/temp_log_buffer_if.sv
// Bundle of the receive, RTC, readout and status signals of temp_log_buffer.
// slave is the logger side, master is the producer/consumer side.
interface temp_log_buffer_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_parity_error;
  logic [5:0]    seconds;
  logic [5:0]    minutes;
  logic [4:0]    hours;
  logic [4:0]    days;
  logic [3:0]    months;
  logic          rd_en;
  logic [33:0]   rd_data;
  logic          rd_valid;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic [7:0]    drop_count;
  logic [7:0]    err_count;
  logic [7:0]    temp_min;
  logic [7:0]    temp_max;
  logic          alarm;

  modport slave (
    input  rx_data, rx_valid, rx_parity_error,
    input  seconds, minutes, hours, days, months,
    input  rd_en,
    output rd_data, rd_valid, count, empty, full,
    output drop_count, err_count, temp_min, temp_max, alarm
  );

  modport master (
    output rx_data, rx_valid, rx_parity_error,
    output seconds, minutes, hours, days, months,
    output rd_en,
    input  rd_data, rd_valid, count, empty, full,
    input  drop_count, err_count, temp_min, temp_max, alarm
  );
endinterface

// File: rtl/temp_log_buffer.sv
// Timestamped circular log of received temperature bytes, with running
// min/max statistics and a hysteretic over-temperature alarm.
module temp_log_buffer #(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] HI_THRESH = 8'd200,
  parameter logic [7:0] LO_THRESH = 8'd180
) (
  input  logic             clk,
  input  logic             reset,
  temp_log_buffer_if.slave bus
);
  localparam int            AW        = $clog2(DEPTH);
  localparam int            CW        = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [0:0]    ST_NORMAL = 1'b0;
  localparam logic [0:0]    ST_ALARM  = 1'b1;

  logic [33:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [7:0]    drop_reg, drop_next;
  logic [7:0]    err_reg, err_next;
  logic [7:0]    min_reg, min_next;
  logic [7:0]    max_reg, max_next;
  logic [0:0]    state_reg, state_next;
  logic [33:0]   rd_data_reg;
  logic          rd_valid_reg;

  logic        accept;
  logic        parity_drop;
  logic        pop;
  logic        full;
  logic [33:0] record;

  assign accept      = bus.rx_valid & ~bus.rx_parity_error;
  assign parity_drop = bus.rx_valid & bus.rx_parity_error;
  assign full        = (count_reg == DEPTH_C);
  assign pop         = bus.rd_en & (count_reg != '0);
  assign record      = {bus.months, bus.days, bus.hours, bus.minutes,
                        bus.seconds, bus.rx_data};

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    drop_next   = drop_reg;
    err_next    = err_reg;
    min_next    = min_reg;
    max_next    = max_reg;
    state_next  = state_reg;

    if (accept) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (pop)    rd_ptr_next = rd_ptr_reg + AW'(1);

    // A push into a full buffer with no pop evicts the oldest record.
    if (accept && !pop) begin
      if (full) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
        if (drop_reg != 8'hFF) drop_next = drop_reg + 8'd1;
      end else begin
        count_next = count_reg + CW'(1);
      end
    end else if (!accept && pop) begin
      count_next = count_reg - CW'(1);
    end

    if (parity_drop && err_reg != 8'hFF) err_next = err_reg + 8'd1;

    if (accept) begin
      if (bus.rx_data < min_reg) min_next = bus.rx_data;
      if (bus.rx_data > max_reg) max_next = bus.rx_data;
      case (state_reg)
        ST_NORMAL: if (bus.rx_data >= HI_THRESH) state_next = ST_ALARM;
        ST_ALARM:  if (bus.rx_data <  LO_THRESH) state_next = ST_NORMAL;
        default:   state_next = ST_NORMAL;
      endcase
    end
  end

  // Storage carries no reset; the cleared count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_reg] <= record;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      drop_reg     <= 8'h00;
      err_reg      <= 8'h00;
      min_reg      <= 8'hFF;
      max_reg      <= 8'h00;
      state_reg    <= ST_NORMAL;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      drop_reg     <= drop_next;
      err_reg      <= err_next;
      min_reg      <= min_next;
      max_reg      <= max_next;
      state_reg    <= state_next;
      rd_valid_reg <= pop;
      if (pop) rd_data_reg <= mem[rd_ptr_reg];
    end
  end

  assign bus.rd_data    = rd_data_reg;
  assign bus.rd_valid   = rd_valid_reg;
  assign bus.count      = count_reg;
  assign bus.empty      = (count_reg == '0);
  assign bus.full       = full;
  assign bus.drop_count = drop_reg;
  assign bus.err_count  = err_reg;
  assign bus.temp_min   = min_reg;
  assign bus.temp_max   = max_reg;
  assign bus.alarm      = (state_reg == ST_ALARM);
endmodule

// File: tb/tb_temp_log_buffer.sv
// Bench for temp_log_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, and a randomized phase.
module tb_temp_log_buffer;
  localparam int         DEPTH = 16;
  localparam logic [7:0] HI    = 8'd200;
  localparam logic [7:0] LO    = 8'd180;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  temp_log_buffer_if #(.DEPTH(DEPTH)) bus_if ();

  temp_log_buffer #(
    .DEPTH(DEPTH), .HI_THRESH(HI), .LO_THRESH(LO)
  ) dut (
    .clk(clk),
    .reset(rst),
    .bus(bus_if.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [33:0] exp_q [$];
  logic [33:0] exp_rd_data  = '0;
  logic        exp_rd_valid = 1'b0;
  int          exp_drop     = 0;
  int          exp_err      = 0;
  logic [7:0]  exp_min      = 8'hFF;
  logic [7:0]  exp_max      = 8'h00;
  logic        exp_alarm    = 1'b0;

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] req);
    n_checks++;
    if (act !== req)
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, req, $time);
    else
      n_pass++;
  endtask

  task automatic model_step();
    logic [33:0] rec;
    logic [7:0]  d;
    if (rst) begin
      exp_q.delete();
      exp_rd_data  = '0;
      exp_rd_valid = 1'b0;
      exp_drop     = 0;
      exp_err      = 0;
      exp_min      = 8'hFF;
      exp_max      = 8'h00;
      exp_alarm    = 1'b0;
    end else begin
      exp_rd_valid = 1'b0;
      if (bus_if.rd_en && exp_q.size() > 0) begin
        exp_rd_data  = exp_q.pop_front();
        exp_rd_valid = 1'b1;
      end
      if (bus_if.rx_valid) begin
        if (bus_if.rx_parity_error) begin
          exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end else begin
          d   = bus_if.rx_data;
          rec = {bus_if.months, bus_if.days, bus_if.hours,
                 bus_if.minutes, bus_if.seconds, d};
          exp_q.push_back(rec);
          if (exp_q.size() > DEPTH) begin
            void'(exp_q.pop_front());
            exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
          end
          if (d < exp_min) exp_min = d;
          if (d > exp_max) exp_max = d;
          if (!exp_alarm && d >= HI) exp_alarm = 1'b1;
          else if (exp_alarm && d < LO) exp_alarm = 1'b0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    #1;
    chk("count",      34'(bus_if.count), 34'(exp_q.size()));
    chk("empty",      34'(bus_if.empty), 34'(exp_q.size() == 0));
    chk("full",       34'(bus_if.full),  34'(exp_q.size() == DEPTH));
    chk("rd_valid",   34'(bus_if.rd_valid), 34'(exp_rd_valid));
    chk("rd_data",    bus_if.rd_data, exp_rd_data);
    chk("drop_count", 34'(bus_if.drop_count), 34'(exp_drop));
    chk("err_count",  34'(bus_if.err_count), 34'(exp_err));
    chk("temp_min",   34'(bus_if.temp_min), 34'(exp_min));
    chk("temp_max",   34'(bus_if.temp_max), 34'(exp_max));
    chk("alarm",      34'(bus_if.alarm), 34'(exp_alarm));
  end

  task automatic step(input logic v, input logic [7:0] d, input logic pe, input logic re);
    @(negedge clk);
    bus_if.rx_valid        = v;
    bus_if.rx_data         = d;
    bus_if.rx_parity_error = pe;
    bus_if.rd_en           = re;
    @(posedge clk);
    #2;
    $display("t=%0t rst=%0b rx_valid=%0b data=%02h perr=%0b rd_en=%0b -> rd_valid=%0b rd_data=%09h count=%0d alarm=%0b",
             $time, rst, v, d, pe, re, bus_if.rd_valid, bus_if.rd_data, bus_if.count, bus_if.alarm);
  endtask

  task automatic set_rtc(input logic [5:0] s, input logic [5:0] m, input logic [4:0] h,
                         input logic [4:0] dy, input logic [3:0] mo);
    bus_if.seconds = s;
    bus_if.minutes = m;
    bus_if.hours   = h;
    bus_if.days    = dy;
    bus_if.months  = mo;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_count"},    34'(bus_if.count), 34'd0);
    chk({tag, "_empty"},    34'(bus_if.empty), 34'd1);
    chk({tag, "_full"},     34'(bus_if.full), 34'd0);
    chk({tag, "_rd_valid"}, 34'(bus_if.rd_valid), 34'd0);
    chk({tag, "_rd_data"},  bus_if.rd_data, 34'd0);
    chk({tag, "_drop"},     34'(bus_if.drop_count), 34'd0);
    chk({tag, "_err"},      34'(bus_if.err_count), 34'd0);
    chk({tag, "_min"},      34'(bus_if.temp_min), 34'hFF);
    chk({tag, "_max"},      34'(bus_if.temp_max), 34'h00);
    chk({tag, "_alarm"},    34'(bus_if.alarm), 34'd0);
  endtask

  logic [7:0] t1 [3]    = '{8'h19, 8'h1E, 8'h14};
  logic [7:0] al_in [5] = '{8'd190, 8'd200, 8'd185, 8'd179, 8'd199};
  logic       al_ex [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    bus_if.rx_valid        = 1'b0;
    bus_if.rx_data         = 8'h00;
    bus_if.rx_parity_error = 1'b0;
    bus_if.rd_en           = 1'b0;
    set_rtc(6'd0, 6'd0, 5'd0, 5'd1, 4'd1);

    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk_reset_values("init");
    rst = 1'b0;

    // Three samples at 00:00:05, then drain
    set_rtc(6'd5, 6'd0, 5'd0, 5'd1, 4'd1);
    for (int i = 0; i < 3; i++) step(1'b1, t1[i], 1'b0, 1'b0);
    chk("t1_count", 34'(bus_if.count), 34'd3);
    chk("t1_min",   34'(bus_if.temp_min), 34'h14);
    chk("t1_max",   34'(bus_if.temp_max), 34'h1E);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t1_pop_valid", 34'(bus_if.rd_valid), 34'd1);
      chk("t1_pop_temp",  34'(bus_if.rd_data[7:0]), 34'(t1[i]));
      chk("t1_pop_sec",   34'(bus_if.rd_data[13:8]), 34'd5);
    end
    chk("t1_empty", 34'(bus_if.empty), 34'd1);

    // Overflow: 18 pushes into 16 slots
    for (int i = 0; i < 18; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("ovf_full",  34'(bus_if.full), 34'd1);
    chk("ovf_count", 34'(bus_if.count), 34'd16);
    chk("ovf_drop",  34'(bus_if.drop_count), 34'd2);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovf_pop_temp", 34'(bus_if.rd_data[7:0]), 34'(i + 2));
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_pop17_valid", 34'(bus_if.rd_valid), 34'd0);

    // Parity error byte
    step(1'b1, 8'h50, 1'b1, 1'b0);
    chk("perr_err",   34'(bus_if.err_count), 34'd1);
    chk("perr_count", 34'(bus_if.count), 34'd0);
    chk("perr_min",   34'(bus_if.temp_min), 34'h00);
    chk("perr_max",   34'(bus_if.temp_max), 34'h1E);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("perr_pop_valid", 34'(bus_if.rd_valid), 34'd0);

    // Alarm hysteresis
    for (int i = 0; i < 5; i++) begin
      step(1'b1, al_in[i], 1'b0, 1'b0);
      chk("alarm_seq", 34'(bus_if.alarm), 34'(al_ex[i]));
    end
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

    // Full buffer, simultaneous push and pop
    for (int i = 0; i < 16; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    chk("pp_valid", 34'(bus_if.rd_valid), 34'd1);
    chk("pp_temp",  34'(bus_if.rd_data[7:0]), 34'h30);
    chk("pp_count", 34'(bus_if.count), 34'd16);
    chk("pp_drop",  34'(bus_if.drop_count), 34'd2);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("pp_last_temp", 34'(bus_if.rd_data[7:0]), 34'hAA);

    // Empty buffer, simultaneous push and pop
    step(1'b1, 8'h42, 1'b0, 1'b1);
    chk("ep_valid", 34'(bus_if.rd_valid), 34'd0);
    chk("ep_count", 34'(bus_if.count), 34'd1);

    // Randomized traffic with varying pop pressure and rare resets
    for (int i = 0; i < 1500; i++) begin
      int pop_pct;
      logic [7:0] d;
      pop_pct = ((i / 250) % 2 == 0) ? 20 : 70;
      set_rtc(6'($urandom_range(0, 59)), 6'($urandom_range(0, 59)),
              5'($urandom_range(0, 23)), 5'($urandom_range(1, 31)),
              4'($urandom_range(1, 12)));
      d = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(170, 210)) : 8'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 99) < 60, d, $urandom_range(0, 9) == 0,
           $urandom_range(0, 99) < pop_pct);
    end
    rst = 1'b0;

    // Saturating error count, then reset during traffic
    for (int i = 0; i < 300; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
    chk("sat_err", 34'(bus_if.err_count), 34'd255);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hF0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 8'hF5, 1'b0, 1'b1);
    chk_reset_values("midrst");
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("midrst_pop_valid", 34'(bus_if.rd_valid), 34'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
